// File: rtl/jt12_wr_arb.sv
// Write arbiter/sequencer for the jt12 MMR port: merges two requesters round-robin into a FIFO
// and replays each entry as a spaced, busy-gated address/data write pair.
module jt12_wr_arb #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned GAP   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req0_valid,
  input  logic                     req0_part,
  input  logic [7:0]               req0_reg,
  input  logic [7:0]               req0_data,
  output logic                     req0_ready,
  input  logic                     req1_valid,
  input  logic                     req1_part,
  input  logic [7:0]               req1_reg,
  input  logic [7:0]               req1_data,
  output logic                     req1_ready,
  input  logic                     ym_busy,
  output logic                     ym_write,
  output logic [1:0]               ym_addr,
  output logic [7:0]               ym_din,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     idle
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(GAP + 1);

  typedef struct packed {
    logic       part;
    logic [7:0] rnum;
    logic [7:0] data;
  } entry_t;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_GAP1, S_DATA, S_HOLD} state_t;

  entry_t         mem [DEPTH];
  entry_t         head;
  entry_t         wdata;
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic           rr_last;
  logic           full, empty;
  logic           win0, win1, push0, push1, push, pop;
  logic [LW-1:0]  level_d;

  state_t         state, state_d;
  logic [CW-1:0]  cnt, cnt_d;
  logic           ym_write_d;
  logic [1:0]     ym_addr_d;
  logic [7:0]     ym_din_d;
  logic           lpart;
  logic [7:0]     lreg;
  logic           addr_vld;
  logic           latch_addr;

  // Arbitration: a contested cycle goes to the requester not served last.
  always_comb begin
    full       = (level == LW'(DEPTH));
    empty      = (level == '0);
    win0       = req0_valid && (!req1_valid || rr_last);
    win1       = req1_valid && (!req0_valid || !rr_last);
    req0_ready = !full && !win1;
    req1_ready = !full && !win0;
    push0      = req0_valid && req0_ready;
    push1      = req1_valid && req1_ready;
    push       = push0 || push1;
    pop        = (state == S_DATA);
    wdata      = push1 ? entry_t'({req1_part, req1_reg, req1_data})
                       : entry_t'({req0_part, req0_reg, req0_data});
    head       = mem[rd_ptr];
    level_d    = level + LW'(push) - LW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      rr_last <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + AW'(1);
        rr_last <= push1;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      level <= level_d;
    end
  end

  // Sequencer next state; outputs are computed for the state being entered.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    ym_write_d = 1'b0;
    ym_addr_d  = ym_addr;
    ym_din_d   = ym_din;
    latch_addr = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty && !ym_busy) begin
          ym_write_d = 1'b1;
          if (addr_vld && head.part == lpart && head.rnum == lreg) begin
            state_d   = S_DATA;
            ym_addr_d = {head.part, 1'b1};
            ym_din_d  = head.data;
          end else begin
            state_d    = S_ADDR;
            ym_addr_d  = {head.part, 1'b0};
            ym_din_d   = head.rnum;
            latch_addr = 1'b1;
          end
        end
      end
      S_ADDR: begin
        state_d = S_GAP1;
        cnt_d   = CW'(GAP - 1);
      end
      S_GAP1: begin
        if (cnt == '0) begin
          state_d    = S_DATA;
          ym_write_d = 1'b1;
          ym_addr_d  = {head.part, 1'b1};
          ym_din_d   = head.data;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      S_DATA: begin
        state_d = S_HOLD;
        cnt_d   = CW'(GAP - 1);
      end
      S_HOLD: begin
        if (cnt != '0) cnt_d = cnt - CW'(1);
        else if (!ym_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      ym_write <= 1'b0;
      ym_addr  <= '0;
      ym_din   <= '0;
      lpart    <= 1'b0;
      lreg     <= '0;
      addr_vld <= 1'b0;
      idle     <= 1'b1;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      ym_write <= ym_write_d;
      ym_addr  <= ym_addr_d;
      ym_din   <= ym_din_d;
      idle     <= (level_d == '0) && (state_d == S_IDLE);
      if (latch_addr) begin
        lpart    <= head.part;
        lreg     <= head.rnum;
        addr_vld <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jt12_wr_arb.sv
// Self-checking bench for jt12_wr_arb: expected MMR writes are queued as requests are
// driven and compared as the DUT strobes ym_write.
module tb_jt12_wr_arb;

  localparam int GAP = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req0_part = 1'b0;
  logic [7:0] req0_reg = '0, req0_data = '0;
  logic       req0_ready;
  logic       req1_valid = 1'b0, req1_part = 1'b0;
  logic [7:0] req1_reg = '0, req1_data = '0;
  logic       req1_ready;
  logic       ym_busy = 1'b0;
  logic       ym_write;
  logic [1:0] ym_addr;
  logic [7:0] ym_din;
  logic [2:0] level;
  logic       idle;

  jt12_wr_arb #(.DEPTH(4), .GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_part(req0_part), .req0_reg(req0_reg),
    .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_part(req1_part), .req1_reg(req1_reg),
    .req1_data(req1_data), .req1_ready(req1_ready),
    .ym_busy(ym_busy), .ym_write(ym_write), .ym_addr(ym_addr), .ym_din(ym_din),
    .level(level), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct { logic [1:0] addr; logic [7:0] din; } wr_t;
  typedef struct { bit rq; bit part; logic [7:0] r; logic [7:0] d; bit hit; } vec_t;

  wr_t  exp_q[$];
  int   wr_log[$];
  int   cyc = 0;
  int   n_cmp = 0, n_bad = 0;
  int   last_wr = 0;
  bit   have_last = 0;
  bit   m_rr = 1'b1;
  bit   m_vld = 1'b0, m_part = 1'b0;
  logic [7:0] m_reg = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Observe every write strobe and score it against the expectation queue.
  always @(negedge clk) begin
    wr_t e;
    if (!rst_n) have_last = 0;
    else if (ym_write) begin
      if (have_last) check("write_spacing_ok", 32'((cyc - last_wr) >= GAP + 1), 1);
      last_wr = cyc;
      have_last = 1;
      wr_log.push_back(cyc);
      if (exp_q.size() == 0) check("unexpected_write", 32'(ym_write), 0);
      else begin
        e = exp_q.pop_front();
        check("ym_addr", 32'(ym_addr), 32'(e.addr));
        check("ym_din", 32'(ym_din), 32'(e.din));
      end
    end
  end

  function automatic bit model_hit(input bit p, input logic [7:0] r);
    return m_vld && m_part == p && m_reg == r;
  endfunction

  task automatic push_exp(input bit p, input logic [7:0] r, input logic [7:0] d, input bit hit);
    wr_t w;
    if (!hit) begin
      w.addr = {p, 1'b0}; w.din = r; exp_q.push_back(w);
      m_vld = 1'b1; m_part = p; m_reg = r;
    end
    w.addr = {p, 1'b1}; w.din = d; exp_q.push_back(w);
  endtask

  // Drive one request for a single cycle; starts and ends at a falling edge. t = push cycle.
  task automatic send(input bit rq, input bit p, input logic [7:0] r, input logic [7:0] d,
                      input bit hit, output int t);
    if (rq) begin req1_valid = 1; req1_part = p; req1_reg = r; req1_data = d; end
    else    begin req0_valid = 1; req0_part = p; req0_reg = r; req0_data = d; end
    #1;
    wr_log.delete();
    check(rq ? "req1_ready" : "req0_ready", 32'(rq ? req1_ready : req0_ready), 1);
    push_exp(p, r, d, hit);
    m_rr = rq;
    @(negedge clk);
    t = cyc;
    req0_valid = 0;
    req1_valid = 0;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (!(idle && exp_q.size() == 0) && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle_timeout", 32'(n < bound), 1);
  endtask

  task automatic wait_write(input bit data_phase, input int bound);
    int n = 0;
    while (!(ym_write && (!data_phase || ym_addr[0])) && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("wait_write_timeout", 32'(n < bound), 1);
  endtask

  initial begin
    vec_t tbl[7];
    int t, b, nw, found;
    tbl[0] = '{0, 0, 8'h28, 8'hF0, 0};
    tbl[1] = '{0, 0, 8'h28, 8'h00, 1};
    tbl[2] = '{1, 1, 8'hA4, 8'h22, 0};
    tbl[3] = '{1, 1, 8'hA0, 8'h69, 0};
    tbl[4] = '{0, 1, 8'hA0, 8'h11, 1};
    tbl[5] = '{0, 0, 8'hA0, 8'h33, 0};
    tbl[6] = '{1, 0, 8'hB4, 8'hC0, 0};

    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("rst_level", 32'(level), 0);
    check("rst_idle", 32'(idle), 1);
    check("rst_write", 32'(ym_write), 0);
    check("rst_addr", 32'(ym_addr), 0);
    check("rst_din", 32'(ym_din), 0);
    check("rst_ready0", 32'(req0_ready), 1);
    check("rst_ready1", 32'(req1_ready), 1);

    // Single writes, with and without address cache hits.
    foreach (tbl[i]) begin
      send(tbl[i].rq, tbl[i].part, tbl[i].r, tbl[i].d, tbl[i].hit, t);
      check("level_after_push", 32'(level), 1);
      wait_idle(60);
      nw = wr_log.size();
      check("n_writes", 32'(nw), tbl[i].hit ? 1 : 2);
      if (nw > 0) begin
        check("first_write_lat", 32'(wr_log[0] - t), 1);
        check("last_write_lat", 32'(wr_log[nw-1] - t), tbl[i].hit ? 1 : GAP + 2);
      end
      check("level_idle", 32'(level), 0);
    end

    // Both requesters contend while busy stalls the sequencer: fill to full.
    begin
      int n0 = 0, n1 = 0, mlvl = 0;
      bit e0, e1;
      ym_busy = 1;
      for (int k = 0; k < 6; k++) begin
        req0_valid = 1; req0_part = 0; req0_reg = 8'h30 + 8'(n0); req0_data = 8'(n0);
        req1_valid = 1; req1_part = 1; req1_reg = 8'h40 + 8'(n1); req1_data = 8'h80 + 8'(n1);
        #1;
        e0 = (mlvl < 4) && m_rr;
        e1 = (mlvl < 4) && !m_rr;
        check("fill_ready0", 32'(req0_ready), 32'(e0));
        check("fill_ready1", 32'(req1_ready), 32'(e1));
        if (e0) begin
          push_exp(0, req0_reg, req0_data, model_hit(0, req0_reg));
          n0++; mlvl++; m_rr = 0;
        end else if (e1) begin
          push_exp(1, req1_reg, req1_data, model_hit(1, req1_reg));
          n1++; mlvl++; m_rr = 1;
        end
        @(negedge clk);
      end
      req0_valid = 0; req1_valid = 0;
      check("fill_level", 32'(level), 4);
      ym_busy = 0;
      wait_write(1, 40);
      check("full_level_at_data", 32'(level), 4);
      check("full_ready0_at_data", 32'(req0_ready), 0);
      @(negedge clk);
      check("level_after_pop", 32'(level), 3);
      check("ready0_after_pop", 32'(req0_ready), 1);
      check("ready1_after_pop", 32'(req1_ready), 1);
      wait_idle(200);
    end

    // Busy held high after a DATA pulse stalls the next pair.
    send(0, 0, 8'h50, 8'hAA, 0, t);
    send(0, 0, 8'h51, 8'hBB, 0, t);
    wait_write(1, 20);
    ym_busy = 1;
    nw = 0;
    repeat (20) begin
      @(negedge clk);
      if (ym_write) nw++;
    end
    check("busy_hold_writes", 32'(nw), 0);
    check("busy_hold_level", 32'(level), 1);
    ym_busy = 0;
    b = cyc;
    found = 0;
    for (int k = 0; k < 6 && found == 0; k++) begin
      @(negedge clk);
      if (ym_write) found = cyc;
    end
    check("addr_after_busy_ok", 32'(found != 0 && found - b >= 1 && found - b <= 2), 1);
    wait_idle(60);

    // Asynchronous reset in the middle of a pair with three entries queued.
    ym_busy = 1;
    send(0, 0, 8'h60, 8'h01, 0, t);
    send(0, 0, 8'h61, 8'h02, 0, t);
    send(0, 0, 8'h62, 8'h03, 0, t);
    check("pre_reset_level", 32'(level), 3);
    ym_busy = 0;
    wait_write(0, 10);
    @(negedge clk);
    rst_n = 0;
    #1;
    check("areset_write", 32'(ym_write), 0);
    check("areset_level", 32'(level), 0);
    check("areset_idle", 32'(idle), 1);
    exp_q.delete();
    m_rr = 1; m_vld = 0;
    nw = 0;
    repeat (3) begin
      @(negedge clk);
      if (ym_write) nw++;
    end
    rst_n = 1;
    repeat (8) begin
      @(negedge clk);
      if (ym_write) nw++;
    end
    check("post_reset_writes", 32'(nw), 0);
    check("post_reset_idle", 32'(idle), 1);
    send(1, 0, 8'h60, 8'h5A, 0, t);
    wait_idle(60);
    check("post_reset_n_writes", 32'(wr_log.size()), 2);
    check("exp_queue_drained", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
